fetch_pipe: RTL and testbench
=============================

FETCH_PIPE -- requirements
Module: fetch_pipe

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, SHALL set the width of every PC and address port.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 stall_i  input  1  SHALL hold the PC and the IF/ID register when high.
REQ-006 flush_i  input  1  SHALL load a bubble into the IF/ID register when high.
REQ-007 redirect_i  input  1  SHALL request a PC change to redirect_target_i when high.
REQ-008 redirect_target_i  input  ADDRESS_WIDTH  SHALL be the redirect (branch/jump) target address.
REQ-009 imem_addr_o  output  ADDRESS_WIDTH  SHALL drive the byte address of the instruction memory.
REQ-010 imem_instr_i  input  32  SHALL be the instruction word returned combinationally for imem_addr_o.
REQ-011 instr_d_o  output  32  SHALL be the registered instruction presented to decode.
REQ-012 pc_d_o  output  ADDRESS_WIDTH  SHALL be the registered PC of instr_d_o.
REQ-013 pc_plus4_d_o  output  ADDRESS_WIDTH  SHALL be pc_d_o + 4, registered.
REQ-014 valid_d_o  output  1  SHALL be high when instr_d_o is a real fetched instruction.

Function
REQ-015 imem_addr_o SHALL equal the fetch PC register combinationally, no added latency.
REQ-016 Fetch-to-decode latency SHALL be exactly one cycle: the word read at PC in cycle N appears on instr_d_o in cycle N+1.
REQ-017 Edge priority SHALL be: rst > redirect_i > stall_i > normal advance.
REQ-018 Normal advance (no stall, no redirect): PC <= PC + 4; IF/ID <= {imem_instr_i, PC, PC+4, valid=1}.
REQ-019 redirect_i high: PC <= redirect_target_i regardless of stall_i; IF/ID SHALL load a bubble (wrong-path word discarded).
REQ-020 stall_i high, redirect_i low: PC and IF/ID SHALL hold, unless flush_i is also high, in which case IF/ID loads a bubble and PC holds.
REQ-021 flush_i high, stall_i low, redirect_i low: IF/ID loads a bubble; PC advances by 4.
REQ-022 Bubble SHALL be instr_d_o=32'h0000_0013 (addi x0,x0,0), pc_d_o=0, pc_plus4_d_o=0, valid_d_o=0.
REQ-023 PC arithmetic SHALL be modulo 2^ADDRESS_WIDTH; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
REQ-024 The block SHALL not check that the PC lies within the 4 KiB ROM; out-of-range addresses pass through unchanged.

Reset
REQ-025 On a rising edge with rst high, PC SHALL load RESET_PC and IF/ID SHALL load a bubble, overriding all other inputs.
REQ-026 rst asserted mid-stall or mid-redirect SHALL discard the pending operation; first fetch after release is from RESET_PC.
REQ-027 In the first cycle after rst deasserts, imem_addr_o=RESET_PC and valid_d_o=0.

Configuration
REQ-028 With macro FETCH_MISALIGN_CHECK_EN defined, the block SHALL add output misalign_o (1 bit, reset 0), set and held sticky when redirect_i is accepted with redirect_target_i[1:0] != 0; while misalign_o is high, PC SHALL hold and IF/ID SHALL load bubbles until rst.
REQ-029 Without FETCH_MISALIGN_CHECK_EN, misalign_o SHALL not exist and redirect_target_i SHALL be loaded unmodified, including low bits.

Verification
REQ-030 Reset then 4 free-running cycles, ROM words A,B,C,D at 0,4,8,12 -> imem_addr_o 0,4,8,12,16; instr_d_o bubble,A,B,C; pc_d_o 0,0,4,8.
REQ-031 stall_i high 2 cycles while PC=8 -> imem_addr_o stays 8, instr_d_o/pc_d_o hold B/4; advance resumes to 12 after release.
REQ-032 redirect_i with target 32'h0000_0100 while stall_i high at PC=12 -> next PC=0x100, valid_d_o=0 one cycle, then instr at 0x100 with pc_d_o=0x100.
REQ-033 flush_i and stall_i together at PC=16 -> PC holds 16, instr_d_o=32'h0000_0013, valid_d_o=0.
REQ-034 Redirect to 32'hFFFF_FFFC, run 2 cycles -> imem_addr_o FFFF_FFFC then 0000_0000; pc_plus4_d_o of that word = 0.
REQ-035 With FETCH_MISALIGN_CHECK_EN: redirect to 32'h0000_0102 -> misalign_o=1 next cycle, PC frozen, valid_d_o=0 until rst; rst clears misalign_o and PC=RESET_PC.

Source files
------------

// File: rtl/fetch_pipe_if.sv
// fetch_pipe_if -- handshake/bus bundle between the fetch stage and its
// neighbours (control, instruction memory, decode).
//
// Signals:
//   stall_i, flush_i, redirect_i, redirect_target_i : pipeline control into fetch
//   imem_addr_o / imem_instr_i                      : instruction memory port
//   instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o      : IF/ID register to decode
//
// Modports:
//   slave  : the fetch stage (consumes control and memory data, drives address and IF/ID)
//   master : the surrounding pipeline / memory model
interface fetch_pipe_if #(
  parameter int unsigned ADDRESS_WIDTH = 32
);
  logic                     stall_i;
  logic                     flush_i;
  logic                     redirect_i;
  logic [ADDRESS_WIDTH-1:0] redirect_target_i;
  logic [ADDRESS_WIDTH-1:0] imem_addr_o;
  logic [31:0]              imem_instr_i;
  logic [31:0]              instr_d_o;
  logic [ADDRESS_WIDTH-1:0] pc_d_o;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_d_o;
  logic                     valid_d_o;

  modport slave (
    input  stall_i, flush_i, redirect_i, redirect_target_i, imem_instr_i,
    output imem_addr_o, instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o
  );

  modport master (
    output stall_i, flush_i, redirect_i, redirect_target_i, imem_instr_i,
    input  imem_addr_o, instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o
  );
endinterface

// File: rtl/fetch_pipe.sv
// fetch_pipe -- instruction fetch stage: PC register plus IF/ID pipeline
// register with stall, flush and redirect control.
//
// Ports:
//   clk         : clock, all state updates on rising edge
//   rst         : synchronous active-high reset (PC <= RESET_PC, IF/ID <= bubble)
//   bus         : fetch_pipe_if.slave (control in, imem port, IF/ID outputs)
//   misalign_o  : sticky misaligned-redirect flag (only with FETCH_MISALIGN_CHECK_EN)
//
// Configuration macro: FETCH_MISALIGN_CHECK_EN
//   When defined, a redirect whose target has nonzero low two bits sets the
//   sticky misalign_o flag; the stage then freezes the PC and issues bubbles
//   until reset. When undefined, redirect targets are loaded unmodified.
//
// Update priority on each edge: rst > redirect > stall > normal advance.
// The bubble is addi x0,x0,0 with zero PC fields and valid low.
module fetch_pipe #(
  parameter int unsigned             ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_pipe_if.slave   bus
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic          misalign_o
`endif
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [31:0]              instr_q;
  logic [ADDRESS_WIDTH-1:0] pc_d_q;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_d_q;
  logic                     valid_q;
  logic [ADDRESS_WIDTH-1:0] pc_next_seq;

  // Modulo-2^ADDRESS_WIDTH increment; wraps silently at the top of memory.
  assign pc_next_seq = pc_q + ADDRESS_WIDTH'(4);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;
  assign misalign_o = misalign_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pc_d_q       <= '0;
      pc_plus4_d_q <= '0;
      valid_q      <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    else if (misalign_q) begin
      // Frozen after a misaligned redirect: PC holds, decode sees only bubbles.
      instr_q      <= NOP_INSTR;
      pc_d_q       <= '0;
      pc_plus4_d_q <= '0;
      valid_q      <= 1'b0;
    end
`endif
    else if (bus.redirect_i) begin
      // Redirect wins over stall; the word fetched this cycle is wrong-path.
      pc_q         <= bus.redirect_target_i;
      instr_q      <= NOP_INSTR;
      pc_d_q       <= '0;
      pc_plus4_d_q <= '0;
      valid_q      <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (bus.redirect_target_i[1:0] != 2'b00) begin
        misalign_q <= 1'b1;
      end
`endif
    end
    else if (bus.stall_i) begin
      // PC always holds under stall; IF/ID holds unless flushed.
      if (bus.flush_i) begin
        instr_q      <= NOP_INSTR;
        pc_d_q       <= '0;
        pc_plus4_d_q <= '0;
        valid_q      <= 1'b0;
      end
    end
    else begin
      pc_q <= pc_next_seq;
      if (bus.flush_i) begin
        instr_q      <= NOP_INSTR;
        pc_d_q       <= '0;
        pc_plus4_d_q <= '0;
        valid_q      <= 1'b0;
      end else begin
        instr_q      <= bus.imem_instr_i;
        pc_d_q       <= pc_q;
        pc_plus4_d_q <= pc_next_seq;
        valid_q      <= 1'b1;
      end
    end
  end

  assign bus.imem_addr_o  = pc_q;
  assign bus.instr_d_o    = instr_q;
  assign bus.pc_d_o       = pc_d_q;
  assign bus.pc_plus4_d_o = pc_plus4_d_q;
  assign bus.valid_d_o    = valid_q;

endmodule

// File: tb/tb_fetch_pipe.sv
module tb_fetch_pipe;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [31:0]  rom [0:1023];
  logic [128:0] got;
  logic [128:0] exp;

  fetch_pipe_if #(.ADDRESS_WIDTH(32)) bus ();

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign;
`endif

  fetch_pipe #(
    .ADDRESS_WIDTH(32),
    .RESET_PC     (RST_PC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_o(misalign)
`endif
  );

  // 4 KiB ROM; higher address bits are ignored so any PC reads something.
  assign bus.imem_instr_i = rom[bus.imem_addr_o[11:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: fetch PC and the IF/ID contents.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc_d;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic        m_mis;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [128:0] snap();
    return {bus.imem_addr_o, bus.instr_d_o, bus.pc_d_o, bus.pc_plus4_d_o, bus.valid_d_o};
  endfunction

  function automatic logic [128:0] bubble_at(input logic [31:0] pc);
    return {pc, NOP, 32'h0, 32'h0, 1'b0};
  endfunction

  function automatic logic [128:0] fetched(input logic [31:0] pc, input logic [31:0] prev_pc);
    logic [9:0] idx;
    idx = prev_pc[11:2];
    return {pc, rom[idx], prev_pc, prev_pc + 32'd4, 1'b1};
  endfunction

  task automatic clear_inputs();
    bus.stall_i           = 1'b0;
    bus.flush_i           = 1'b0;
    bus.redirect_i        = 1'b0;
    bus.redirect_target_i = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Next-state of the model from the inputs currently applied.
  task automatic model_step();
    logic [31:0] word;
    logic        make_bubble;
    word = rom[m_pc[11:2]];
    make_bubble = 1'b0;
    if (rst) begin
      m_pc = RST_PC;
      m_mis = 1'b0;
      make_bubble = 1'b1;
    end else if (m_mis) begin
      make_bubble = 1'b1;
    end else if (bus.redirect_i) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      m_mis = (bus.redirect_target_i % 4) != 0;
`endif
      m_pc = bus.redirect_target_i;
      make_bubble = 1'b1;
    end else if (bus.stall_i) begin
      make_bubble = bus.flush_i;
    end else if (bus.flush_i) begin
      m_pc = m_pc + 32'd4;
      make_bubble = 1'b1;
    end else begin
      m_instr = word;
      m_pc_d  = m_pc;
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end
    if (make_bubble) begin
      m_instr = NOP;
      m_pc_d  = 32'h0;
      m_pc4   = 32'h0;
      m_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    bus.stall_i = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_target_i = 32'h0000_0400;
    tick();
    got = snap(); exp = bubble_at(RST_PC); checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_state got=%h exp=%h", got, exp); end
    clear_inputs();
    rst = 1'b0;
    tick();
    // First cycle after release still shows the bubble, then fetch starts at RESET_PC.
    got = snap(); exp = fetched(RST_PC + 32'd4, RST_PC); checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_first_fetch got=%h exp=%h", got, exp); end
  endtask

  task automatic test_free_run();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      got = snap();
      exp = (k == 0) ? bubble_at(32'h0) : fetched(32'(4 * k), 32'(4 * (k - 1)));
      checks++;
      if (got !== exp) begin failures++; $display("FAIL free_run_%0d got=%h exp=%h", k, got, exp); end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    tick();
    bus.stall_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      got = snap(); exp = fetched(32'd8, 32'd4); checks++;
      if (got !== exp) begin failures++; $display("FAIL stall_hold_%0d got=%h exp=%h", k, got, exp); end
    end
    bus.stall_i = 1'b0;
    tick();
    got = snap(); exp = fetched(32'd12, 32'd8); checks++;
    if (got !== exp) begin failures++; $display("FAIL stall_release got=%h exp=%h", got, exp); end
  endtask

  task automatic test_redirect();
    bus.stall_i = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_target_i = 32'h0000_0100;
    tick();
    clear_inputs();
    got = snap(); exp = bubble_at(32'h0000_0100); checks++;
    if (got !== exp) begin failures++; $display("FAIL redirect_bubble got=%h exp=%h", got, exp); end
    tick();
    got = snap(); exp = fetched(32'h0000_0104, 32'h0000_0100); checks++;
    if (got !== exp) begin failures++; $display("FAIL redirect_target got=%h exp=%h", got, exp); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    bus.stall_i = 1'b1;
    bus.flush_i = 1'b1;
    tick();
    got = snap(); exp = bubble_at(32'd16); checks++;
    if (got !== exp) begin failures++; $display("FAIL flush_stall got=%h exp=%h", got, exp); end
    bus.stall_i = 1'b0;
    tick();
    got = snap(); exp = bubble_at(32'd20); checks++;
    if (got !== exp) begin failures++; $display("FAIL flush_advance got=%h exp=%h", got, exp); end
    clear_inputs();
  endtask

  task automatic test_wrap();
    bus.redirect_i = 1'b1;
    bus.redirect_target_i = 32'hFFFF_FFFC;
    tick();
    clear_inputs();
    got = snap(); exp = bubble_at(32'hFFFF_FFFC); checks++;
    if (got !== exp) begin failures++; $display("FAIL wrap_redirect got=%h exp=%h", got, exp); end
    tick();
    got = snap(); exp = fetched(32'h0, 32'hFFFF_FFFC); checks++;
    if (got !== exp) begin failures++; $display("FAIL wrap_around got=%h exp=%h", got, exp); end
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    do_reset();
    tick();
    bus.redirect_i = 1'b1;
    bus.redirect_target_i = 32'h0000_0102;
    tick();
    clear_inputs();
    got = {misalign, snap()}; exp = {1'b1, bubble_at(32'h0000_0102)}; checks++;
    if (got !== exp) begin failures++; $display("FAIL misalign_set got=%h exp=%h", got, exp); end
    for (int k = 0; k < 3; k++) begin
      bus.redirect_i = (k == 1);
      bus.redirect_target_i = 32'h0000_0200;
      tick();
      got = {misalign, snap()}; exp = {1'b1, bubble_at(32'h0000_0102)}; checks++;
      if (got !== exp) begin failures++; $display("FAIL misalign_frozen_%0d got=%h exp=%h", k, got, exp); end
    end
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got = {misalign, snap()}; exp = {1'b0, bubble_at(RST_PC)}; checks++;
    if (got !== exp) begin failures++; $display("FAIL misalign_clear got=%h exp=%h", got, exp); end
  endtask
`else
  task automatic test_unaligned_passthru();
    bus.redirect_i = 1'b1;
    bus.redirect_target_i = 32'h0000_0102;
    tick();
    clear_inputs();
    got = snap(); exp = bubble_at(32'h0000_0102); checks++;
    if (got !== exp) begin failures++; $display("FAIL unaligned_load got=%h exp=%h", got, exp); end
    tick();
    got = snap(); exp = fetched(32'h0000_0106, 32'h0000_0102); checks++;
    if (got !== exp) begin failures++; $display("FAIL unaligned_fetch got=%h exp=%h", got, exp); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst                   = (i == 0) || ($urandom_range(0, 39) == 0);
      bus.stall_i           = ($urandom_range(0, 3) == 0);
      bus.flush_i           = ($urandom_range(0, 5) == 0);
      bus.redirect_i        = ($urandom_range(0, 7) == 0);
      bus.redirect_target_i = $urandom;
      if ($urandom_range(0, 15) != 0) bus.redirect_target_i[1:0] = 2'b00;
      model_step();
      tick();
      got = snap(); exp = {m_pc, m_instr, m_pc_d, m_pc4, m_valid}; checks++;
      if (got !== exp) begin failures++; $display("FAIL random_%0d got=%h exp=%h", i, got, exp); end
`ifdef FETCH_MISALIGN_CHECK_EN
      checks++;
      if (misalign !== m_mis) begin
        failures++; $display("FAIL random_misalign_%0d got=%b exp=%b", i, misalign, m_mis);
      end
`endif
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_pc = RST_PC; m_instr = NOP; m_pc_d = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rst = 1'b1;
    clear_inputs();

    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_flush();
    test_wrap();
`ifdef FETCH_MISALIGN_CHECK_EN
    test_misalign();
`else
    test_unaligned_passthru();
`endif
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
